// File: rtl/axi_fir8_slave_regs.sv
// AXI4-Lite register slave for the 8-tap FIR: coefficient banks and sample/result mailboxes.
// Define AXI_FIR8_IRQ_EN to enable the level interrupt and the CTRL.IE bit.
module axi_fir8_slave_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int COEF_WIDTH         = 16,
    parameter int SAMPLE_WIDTH       = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [8*COEF_WIDTH-1:0]         coef_o,
    output logic                            coef_update_o,
    output logic [SAMPLE_WIDTH-1:0]         sample_tdata,
    output logic                            sample_tvalid,
    input  logic                            sample_tready,
    input  logic [SAMPLE_WIDTH-1:0]         result_tdata,
    input  logic                            result_tvalid,
    output logic                            irq_o
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef logic [DW-1:0] word_t;

    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    aw_full_q, aw_full_d;
    logic                    w_full_q, w_full_d;
    logic [3:0]              awidx_q, awidx_d;
    word_t                   wdata_q, wdata_d;
    logic [SW-1:0]           wstrb_q, wstrb_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [1:0]              rresp_q, rresp_d;
    word_t                   rdata_q, rdata_d;
    logic                    rd_res_q, rd_res_d;
    logic                    en_q, en_d;
    logic                    ie_q, ie_d;
    logic                    ovr_q, ovr_d;
    logic                    res_valid_q, res_valid_d;
    logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
    logic                    stv_q, stv_d;
    logic [SAMPLE_WIDTH-1:0] result_q, result_d;
    logic [COEF_WIDTH-1:0]   shadow_q [8];
    logic [COEF_WIDTH-1:0]   shadow_d [8];
    logic [8*COEF_WIDTH-1:0] coef_q, coef_d;
    logic                    upd_q, upd_d;
    logic                    irq_q, irq_d;

    logic                    aw_hs, w_hs, ar_hs, do_wr, res_clr;
    logic                    ovr_set, ovr_clr;
    logic [3:0]              ridx;
    word_t                   rd_word, wm;
    logic                    unused_ok;

    function automatic word_t merge(input word_t old, input word_t wd,
                                    input logic [SW-1:0] st);
        word_t r;
        r = old;
        for (int b = 0; b < SW; b++) begin
            if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [2:0] tap_of(input logic [3:0] idx);
        return 3'(idx - 4'd4);
    endfunction

    // Register view shared by the read mux and the write byte-merge.
    function automatic word_t reg_rd(input logic [3:0] idx);
        word_t r;
        r = '0;
        case (idx)
            4'd0: r = word_t'({ie_q, 1'b0, en_q});
            4'd1: r = word_t'({ovr_q, res_valid_q, stv_q});
            4'd2: r = word_t'(sample_q);
            4'd3: r = {{(DW-SAMPLE_WIDTH){result_q[SAMPLE_WIDTH-1]}}, result_q};
            4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11:
                r = word_t'(shadow_q[tap_of(idx)]);
            default: r = '0;
        endcase
        return r;
    endfunction

    assign aw_hs   = awready_q & s_axi_awvalid;
    assign w_hs    = wready_q & s_axi_wvalid;
    assign ar_hs   = arready_q & s_axi_arvalid;
    assign do_wr   = aw_full_q & w_full_q;
    assign res_clr = rvalid_q & s_axi_rready & rd_res_q;
    assign ridx    = s_axi_araddr[5:2];
    assign rd_word = reg_rd(ridx);
    assign wm      = merge(reg_rd(awidx_q), wdata_q, wstrb_q);

    always_comb begin
        awready_d   = 1'b0;
        wready_d    = 1'b0;
        arready_d   = 1'b0;
        aw_full_d   = aw_full_q;
        w_full_d    = w_full_q;
        awidx_d     = awidx_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        rd_res_d    = rd_res_q;
        en_d        = en_q;
        ie_d        = ie_q;
        res_valid_d = res_valid_q;
        sample_d    = sample_q;
        stv_d       = stv_q;
        result_d    = result_q;
        shadow_d    = shadow_q;
        coef_d      = coef_q;
        upd_d       = 1'b0;
        ovr_set     = 1'b0;
        ovr_clr     = 1'b0;

        awready_d = s_axi_awvalid & ~awready_q & ~aw_full_q & ~bvalid_q;
        wready_d  = s_axi_wvalid & ~wready_q & ~w_full_q & ~bvalid_q;
        if (aw_hs) begin
            aw_full_d = 1'b1;
            awidx_d   = s_axi_awaddr[5:2];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
        end
        if (bvalid_q & s_axi_bready) bvalid_d = 1'b0;

        if (stv_q & sample_tready) stv_d = 1'b0;

        if (do_wr) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = OKAY;
            case (awidx_q)
                4'd0: begin
                    en_d = wm[0];
`ifdef AXI_FIR8_IRQ_EN
                    ie_d = wm[2];
`endif
                    if (wm[1]) begin
                        for (int i = 0; i < 8; i++) begin
                            coef_d[i*COEF_WIDTH +: COEF_WIDTH] = shadow_q[i];
                        end
                        upd_d = 1'b1;
                    end
                end
                4'd1: ovr_clr = wstrb_q[0] & wdata_q[2];
                4'd2: begin
                    // A pending sample is never overwritten while streaming.
                    if (en_q & stv_q) begin
                        ovr_set = 1'b1;
                    end else begin
                        sample_d = wm[SAMPLE_WIDTH-1:0];
                        if (en_q) stv_d = 1'b1;
                    end
                end
                4'd3: ;
                4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11:
                    shadow_d[tap_of(awidx_q)] = wm[COEF_WIDTH-1:0];
                default: bresp_d = SLVERR;
            endcase
        end

        arready_d = s_axi_arvalid & ~arready_q & ~rvalid_q;
        if (rvalid_q & s_axi_rready) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
            rresp_d  = (ridx >= 4'd12) ? SLVERR : OKAY;
            rd_res_d = (ridx == 4'd3);
        end

        // A result landing on the clearing read wins and is not an overrun.
        if (result_tvalid) begin
            result_d    = result_tdata;
            res_valid_d = 1'b1;
            if (res_valid_q & ~res_clr) ovr_set = 1'b1;
        end else if (res_clr) begin
            res_valid_d = 1'b0;
        end

        ovr_d = (ovr_q & ~ovr_clr) | ovr_set;

`ifdef AXI_FIR8_IRQ_EN
        irq_d = ie_q & (res_valid_q | ovr_q);
`else
        irq_d = 1'b0;
`endif
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            aw_full_q   <= 1'b0;
            w_full_q    <= 1'b0;
            awidx_q     <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= OKAY;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rresp_q     <= OKAY;
            rdata_q     <= '0;
            rd_res_q    <= 1'b0;
            en_q        <= 1'b0;
            ie_q        <= 1'b0;
            ovr_q       <= 1'b0;
            res_valid_q <= 1'b0;
            sample_q    <= '0;
            stv_q       <= 1'b0;
            result_q    <= '0;
            shadow_q    <= '{default: '0};
            coef_q      <= '0;
            upd_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            aw_full_q   <= aw_full_d;
            w_full_q    <= w_full_d;
            awidx_q     <= awidx_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            rd_res_q    <= rd_res_d;
            en_q        <= en_d;
            ie_q        <= ie_d;
            ovr_q       <= ovr_d;
            res_valid_q <= res_valid_d;
            sample_q    <= sample_d;
            stv_q       <= stv_d;
            result_q    <= result_d;
            shadow_q    <= shadow_d;
            coef_q      <= coef_d;
            upd_q       <= upd_d;
            irq_q       <= irq_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign coef_o        = coef_q;
    assign coef_update_o = upd_q;
    assign sample_tdata  = sample_q;
    assign sample_tvalid = stv_q;
    assign irq_o         = irq_q;

    assign unused_ok = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], wm};

endmodule

// File: tb/tb_axi_fir8_slave_regs.sv
// Directed bench for axi_fir8_slave_regs: AXI-Lite register access, APPLY,
// sample/result mailboxes, SLVERR and interrupt (AXI_FIR8_IRQ_EN aware).
module tb_axi_fir8_slave_regs;

    logic         clk = 1'b0;
    logic         rstn;
    logic [5:0]   awaddr, araddr;
    logic         awvalid, awready, wvalid, wready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic         bvalid, bready, arvalid, arready, rvalid, rready;
    logic [127:0] coef;
    logic         coef_upd;
    logic [15:0]  s_tdata, r_tdata;
    logic         s_tvalid, s_tready, r_tvalid;
    logic         irq;

    int n_chk  = 0;
    int n_fail = 0;
    int upd_cnt = 0;
    int b_cnt  = 0;

`ifdef AXI_FIR8_IRQ_EN
    localparam logic [31:0] CTRL_IE = 32'h4;
`else
    localparam logic [31:0] CTRL_IE = 32'h0;
`endif

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (coef_upd) upd_cnt++;
        if (bvalid && bready) b_cnt++;
    end

    axi_fir8_slave_regs dut (
        .ACLK          (clk),
        .ARESETN       (rstn),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .coef_o        (coef),
        .coef_update_o (coef_upd),
        .sample_tdata  (s_tdata),
        .sample_tvalid (s_tvalid),
        .sample_tready (s_tready),
        .result_tdata  (r_tdata),
        .result_tvalid (r_tvalid),
        .irq_o         (irq)
    );

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int awdly,
                             output logic [1:0] resp);
        bit awd = 0, wd = 0, got = 0, hsa, hsw;
        resp   = 2'b11;
        awaddr = a;
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        for (int i = 0; i < 40 && !(awd && wd); i++) begin
            if (i == awdly && !awd) awvalid = 1'b1;
            hsa = awvalid && awready;
            hsw = wvalid && wready;
            tick();
            if (hsa) begin awvalid = 1'b0; awd = 1; end
            if (hsw) begin wvalid = 1'b0; wd = 1; end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bvalid) begin resp = bresp; got = 1; end
            tick();
        end
        bready = 1'b0;
        check("wr_handshake", {awd, wd, got}, 3'b111);
    endtask

    task automatic axi_read(input logic [5:0] a, input bit pulse,
                            input logic [15:0] pd,
                            output logic [31:0] d, output logic [1:0] resp);
        bit ard = 0, got = 0, hs;
        d       = 32'hDEADBEEF;
        resp    = 2'b11;
        araddr  = a;
        arvalid = 1'b1;
        for (int i = 0; i < 20 && !ard; i++) begin
            hs = arvalid && arready;
            tick();
            if (hs) begin arvalid = 1'b0; ard = 1; end
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (rvalid) begin
                d    = rdata;
                resp = rresp;
                got  = 1;
                if (pulse) begin r_tdata = pd; r_tvalid = 1'b1; end
            end
            tick();
        end
        r_tvalid = 1'b0;
        rready   = 1'b0;
        check("rd_handshake", {ard, got}, 2'b11);
    endtask

    task automatic pulse_result(input logic [15:0] v);
        r_tdata  = v;
        r_tvalid = 1'b1;
        tick();
        r_tvalid = 1'b0;
    endtask

    initial begin
        logic [1:0]  br, rr;
        logic [31:0] rd;
        int          bc;

        rstn = 1'b0;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
        bready = 0; araddr = '0; arvalid = 0; rready = 0;
        s_tready = 0; r_tdata = '0; r_tvalid = 0;
        repeat (3) tick();
        check("rst_ready", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        check("rst_resp", {bresp, rresp, rdata}, 36'h0);
        check("rst_coef", coef, 128'h0);
        check("rst_misc", {coef_upd, s_tvalid, s_tdata, irq}, 19'h0);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            axi_write(6'(16 + 4*i), 32'(i + 1), 4'hF, 0, br);
            check("coef_bresp", br, 2'b00);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(16 + 4*i), 0, '0, rd, rr);
            check("coef_rdata", rd, 32'(i + 1));
            check("coef_rresp", rr, 2'b00);
        end
        check("coef_unapplied", coef, 128'h0);

        for (int i = 4; i < 8; i++) axi_write(6'(16 + 4*i), 32'(i + 1), 4'hF, 0, br);
        upd_cnt = 0;
        axi_write(6'h00, 32'h2, 4'hF, 0, br);
        repeat (3) tick();
        check("apply_pulse", upd_cnt, 1);
        check("apply_coef", coef, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        axi_read(6'h00, 0, '0, rd, rr);
        check("apply_ctrl_rd", rd, 32'h0);

        axi_write(6'h00, 32'h1, 4'hF, 0, br);
        axi_write(6'h08, 32'h1234, 4'hF, 0, br);
        check("smp_load", {s_tvalid, s_tdata}, {1'b1, 16'h1234});
        axi_write(6'h08, 32'h5678, 4'hF, 0, br);
        check("smp_hold", {s_tvalid, s_tdata}, {1'b1, 16'h1234});
        axi_read(6'h04, 0, '0, rd, rr);
        check("smp_status_ovr", rd, 32'h5);
        axi_write(6'h04, 32'h4, 4'hF, 0, br);
        axi_read(6'h04, 0, '0, rd, rr);
        check("smp_status_w1c", rd, 32'h1);
        s_tready = 1'b1;
        tick();
        s_tready = 1'b0;
        check("smp_consumed", s_tvalid, 1'b0);
        axi_write(6'h00, 32'h0, 4'hF, 0, br);
        axi_write(6'h08, 32'h0042, 4'hF, 0, br);
        check("smp_en0", {s_tvalid, s_tdata}, {1'b0, 16'h0042});
        axi_write(6'h08, 32'h0000ABCD, 4'h2, 0, br);
        axi_read(6'h08, 0, '0, rd, rr);
        check("smp_wstrb", rd, 32'h0000AB42);

        pulse_result(16'hFFF0);
        axi_read(6'h04, 0, '0, rd, rr);
        check("res_status_set", rd, 32'h2);
        axi_read(6'h0C, 0, '0, rd, rr);
        check("res_signext", rd, 32'hFFFFFFF0);
        axi_read(6'h04, 0, '0, rd, rr);
        check("res_status_clr", rd, 32'h0);
        pulse_result(16'h0011);
        axi_read(6'h0C, 1, 16'h0022, rd, rr);
        check("res_race_data", rd, 32'h11);
        axi_read(6'h04, 0, '0, rd, rr);
        check("res_race_status", rd, 32'h2);
        axi_read(6'h0C, 0, '0, rd, rr);
        check("res_race_new", rd, 32'h22);
        pulse_result(16'h0001);
        pulse_result(16'h0002);
        axi_read(6'h04, 0, '0, rd, rr);
        check("res_ovr_status", rd, 32'h6);
        axi_read(6'h0C, 0, '0, rd, rr);
        check("res_ovr_data", rd, 32'h2);
        axi_write(6'h04, 32'h4, 4'hF, 0, br);
        axi_read(6'h04, 0, '0, rd, rr);
        check("res_ovr_w1c", rd, 32'h0);

        axi_write(6'h00, 32'h4, 4'hF, 0, br);
        axi_read(6'h00, 0, '0, rd, rr);
        check("irq_ctrl_rd", rd, CTRL_IE);
        pulse_result(16'h0007);
        check("irq_latency", irq, 1'b0);
        tick();
`ifdef AXI_FIR8_IRQ_EN
        check("irq_set", irq, 1'b1);
`else
        check("irq_off", irq, 1'b0);
`endif
        axi_read(6'h0C, 0, '0, rd, rr);
        repeat (2) tick();
        check("irq_clr", irq, 1'b0);

        axi_write(6'h30, 32'hFFFFFFFF, 4'hF, 0, br);
        check("unmap_bresp", br, 2'b10);
        axi_read(6'h3C, 0, '0, rd, rr);
        check("unmap_rd", {rr, rd}, {2'b10, 32'h0});
        axi_read(6'h10, 0, '0, rd, rr);
        check("unmap_coef0", rd, 32'h1);
        axi_read(6'h00, 0, '0, rd, rr);
        check("unmap_ctrl", rd, CTRL_IE);
        check("unmap_active", coef, 128'h0008_0007_0006_0005_0004_0003_0002_0001);

        bc = b_cnt;
        axi_write(6'h14, 32'h55, 4'hF, 3, br);
        repeat (3) tick();
        check("awdly_bresp", br, 2'b00);
        check("awdly_bcount", b_cnt - bc, 1);
        check("awdly_bidle", bvalid, 1'b0);
        axi_read(6'h14, 0, '0, rd, rr);
        check("awdly_rd", rd, 32'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
